// File: rtl/task2_pkg.sv
// task2_pkg: constants and types shared by the task2 datapath blocks.
//   TASK2_DATA_W     : default data word width (4 bits)
//   task2_word_t     : data word of TASK2_DATA_W bits
//   TASK2_SEL_CNT_W  : width of the optional select-transition counter
package task2_pkg;

  localparam int TASK2_DATA_W    = 4;
  localparam int TASK2_SEL_CNT_W = 8;

  typedef logic [TASK2_DATA_W-1:0] task2_word_t;

  // All-ones value of the select counter, used as its saturation limit.
  function automatic logic [TASK2_SEL_CNT_W-1:0] task2_sel_cnt_max();
    return {TASK2_SEL_CNT_W{1'b1}};
  endfunction

endpackage : task2_pkg

// File: rtl/task2_12_mux2_core.sv
// task2_12_mux2_core: purely combinational WIDTH-bit 2:1 select.
// Ports:
//   d0 [WIDTH] : word routed to y when s = 0
//   d1 [WIDTH] : word routed to y when s = 1
//   s          : select bit
//   y  [WIDTH] : selected word, bit i taken from bit i of the chosen input
module task2_12_mux2_core
  import task2_pkg::*;
#(
  parameter int WIDTH = TASK2_DATA_W
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  // Per-bit select keeps the bit-for-bit routing explicit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign y[gi] = s ? d1[gi] : d0[gi];
  end

endmodule : task2_12_mux2_core

// File: rtl/task2_12_mux2.sv
// task2_12_mux2: 2:1 word multiplexer with a combinational result and a
// registered copy of the result and the select bit.
// Optional feature: define TASK2_12_MUX2_SEL_CNT_EN to add the sel_cnt port,
// a saturating count of clock edges on which s differs from s_q.
// Ports:
//   clk            : single clock, state updates on rising edge
//   rst            : synchronous active-high reset
//   d0, d1 [WIDTH] : data words selected by s = 0 / s = 1
//   s              : select bit
//   y      [WIDTH] : combinational mux result (never reset)
//   y_q    [WIDTH] : registered mux result, RESET_VAL after reset
//   s_q            : registered s, aligned with y_q, 0 after reset
//   sel_cnt [8]    : (optional) saturating select-transition count
module task2_12_mux2
  import task2_pkg::*;
#(
  parameter int               WIDTH     = TASK2_DATA_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           d0,
  input  logic [WIDTH-1:0]           d1,
  input  logic                       s,
  output logic [WIDTH-1:0]           y,
  output logic [WIDTH-1:0]           y_q,
`ifdef TASK2_12_MUX2_SEL_CNT_EN
  output logic [TASK2_SEL_CNT_W-1:0] sel_cnt,
`endif
  output logic                       s_q
);

  logic [WIDTH-1:0] y_d;
  logic             s_d;

  task2_12_mux2_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .d0 (d0),
    .d1 (d1),
    .s  (s),
    .y  (y)
  );

  assign y_d = y;
  assign s_d = s;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= RESET_VAL;
      s_q <= 1'b0;
    end else begin
      y_q <= y_d;
      s_q <= s_d;
    end
  end

`ifdef TASK2_12_MUX2_SEL_CNT_EN
  logic [TASK2_SEL_CNT_W-1:0] sel_cnt_q;
  logic [TASK2_SEL_CNT_W-1:0] sel_cnt_d;

  // A transition is the incoming select differing from the one captured on
  // the previous edge; the count holds once it reaches all-ones.
  always_comb begin
    sel_cnt_d = sel_cnt_q;
    if ((s != s_q) && (sel_cnt_q != task2_sel_cnt_max())) begin
      sel_cnt_d = sel_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_cnt_q <= '0;
    end else begin
      sel_cnt_q <= sel_cnt_d;
    end
  end

  assign sel_cnt = sel_cnt_q;
`endif

endmodule : task2_12_mux2

// File: tb/tb_task2_12_mux2.sv
module tb_task2_12_mux2;
  import task2_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] d0;
  logic [3:0] d1;
  logic       s;
  logic [3:0] y;
  logic [3:0] y_q;
  logic       s_q;
`ifdef TASK2_12_MUX2_SEL_CNT_EN
  logic [7:0] sel_cnt;
`endif

  int n_cmp;
  int n_bad;

  task2_12_mux2 #(
    .WIDTH     (4),
    .RESET_VAL (4'h0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .d0      (d0),
    .d1      (d1),
    .s       (s),
    .y       (y),
    .y_q     (y_q),
`ifdef TASK2_12_MUX2_SEL_CNT_EN
    .sel_cnt (sel_cnt),
`endif
    .s_q     (s_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d0 = 4'h5; d1 = 4'hA; s = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (y !== 4'hA) begin
      n_bad++; $display("FAIL reset_y: got %h want %h", y, 4'hA);
    end
    n_cmp++;
    if (y_q !== 4'h0) begin
      n_bad++; $display("FAIL reset_y_q: got %h want %h", y_q, 4'h0);
    end
    n_cmp++;
    if (s_q !== 1'b0) begin
      n_bad++; $display("FAIL reset_s_q: got %b want %b", s_q, 1'b0);
    end
`ifdef TASK2_12_MUX2_SEL_CNT_EN
    n_cmp++;
    if (sel_cnt !== 8'd0) begin
      n_bad++; $display("FAIL reset_sel_cnt: got %0d want 0", sel_cnt);
    end
`endif
    $display("reset: y=%h y_q=%h s_q=%b", y, y_q, s_q);
  endtask

  task automatic test_sweep();
    logic [2:0] vec   [8] = '{3'b000, 3'b001, 3'b010, 3'b011,
                              3'b100, 3'b101, 3'b110, 3'b111};
    logic       exp_y [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d0 = {3'b000, vec[i][2]};
      d1 = {3'b000, vec[i][1]};
      s  = vec[i][0];
      #1;
      n_cmp++;
      if (y !== {3'b000, exp_y[i]}) begin
        n_bad++; $display("FAIL sweep_y[%0d]: got %h want %h", i, y, {3'b000, exp_y[i]});
      end
      tick();
      n_cmp++;
      if (y_q !== {3'b000, exp_y[i]}) begin
        n_bad++; $display("FAIL sweep_y_q[%0d]: got %h want %h", i, y_q, {3'b000, exp_y[i]});
      end
      n_cmp++;
      if (s_q !== vec[i][0]) begin
        n_bad++; $display("FAIL sweep_s_q[%0d]: got %b want %b", i, s_q, vec[i][0]);
      end
      $display("sweep %0d: d0=%h d1=%h s=%b y=%h y_q=%h", i, d0, d1, s, y, y_q);
    end
  endtask

  task automatic test_toggle();
    logic [3:0] prev_y;
    logic       prev_s;
    d0 = 4'h3; d1 = 4'hC; s = 1'b0;
    tick();
    prev_y = 4'h3; prev_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s = ~s;
      #1;
      n_cmp++;
      if (y !== (s ? 4'hC : 4'h3)) begin
        n_bad++; $display("FAIL toggle_y[%0d]: got %h want %h", i, y, (s ? 4'hC : 4'h3));
      end
      // Before the edge the register still shows the previous selection.
      n_cmp++;
      if (y_q !== prev_y) begin
        n_bad++; $display("FAIL toggle_lag[%0d]: got %h want %h", i, y_q, prev_y);
      end
      n_cmp++;
      if (s_q !== prev_s) begin
        n_bad++; $display("FAIL toggle_s_lag[%0d]: got %b want %b", i, s_q, prev_s);
      end
      tick();
      prev_y = s ? 4'hC : 4'h3;
      prev_s = s;
      n_cmp++;
      if (y_q !== prev_y) begin
        n_bad++; $display("FAIL toggle_y_q[%0d]: got %h want %h", i, y_q, prev_y);
      end
      $display("toggle %0d: s=%b y=%h y_q=%h s_q=%b", i, s, y, y_q, s_q);
    end
  endtask

  task automatic test_full_width();
    d0 = 4'hF; d1 = 4'h0; s = 1'b0;
    #1;
    n_cmp++;
    if (y !== 4'hF) begin
      n_bad++; $display("FAIL full_y_s0: got %h want %h", y, 4'hF);
    end
    tick();
    n_cmp++;
    if (y_q !== 4'hF) begin
      n_bad++; $display("FAIL full_y_q_s0: got %h want %h", y_q, 4'hF);
    end
    s = 1'b1;
    #1;
    n_cmp++;
    if (y !== 4'h0) begin
      n_bad++; $display("FAIL full_y_s1: got %h want %h", y, 4'h0);
    end
    tick();
    n_cmp++;
    if (y_q !== 4'h0) begin
      n_bad++; $display("FAIL full_y_q_s1: got %h want %h", y_q, 4'h0);
    end
    $display("full width: d0=%h d1=%h y=%h y_q=%h", d0, d1, y, y_q);
  endtask

  task automatic test_equal_inputs();
    d0 = 4'h9; d1 = 4'h9;
    for (int i = 0; i < 2; i++) begin
      s = i[0];
      #1;
      n_cmp++;
      if (y !== 4'h9) begin
        n_bad++; $display("FAIL equal_y[s=%0d]: got %h want %h", i, y, 4'h9);
      end
      tick();
      $display("equal: s=%b y=%h", s, y);
    end
  endtask

  task automatic test_mid_reset();
    d0 = 4'h3; d1 = 4'hC; s = 1'b1; rst = 1'b0;
    tick();
    n_cmp++;
    if (y_q !== 4'hC) begin
      n_bad++; $display("FAIL midrst_pre: got %h want %h", y_q, 4'hC);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (y !== 4'hC) begin
      n_bad++; $display("FAIL midrst_y_during: got %h want %h", y, 4'hC);
    end
    tick();
    n_cmp++;
    if (y_q !== 4'h0) begin
      n_bad++; $display("FAIL midrst_y_q: got %h want %h", y_q, 4'h0);
    end
    n_cmp++;
    if (s_q !== 1'b0) begin
      n_bad++; $display("FAIL midrst_s_q: got %b want %b", s_q, 1'b0);
    end
    n_cmp++;
    if (y !== 4'hC) begin
      n_bad++; $display("FAIL midrst_y_after: got %h want %h", y, 4'hC);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (y_q !== 4'hC) begin
      n_bad++; $display("FAIL midrst_resume: got %h want %h", y_q, 4'hC);
    end
    n_cmp++;
    if (s_q !== 1'b1) begin
      n_bad++; $display("FAIL midrst_resume_s_q: got %b want %b", s_q, 1'b1);
    end
    $display("mid reset: y=%h y_q=%h s_q=%b", y, y_q, s_q);
  endtask

`ifdef TASK2_12_MUX2_SEL_CNT_EN
  task automatic test_sel_cnt();
    rst = 1'b1; s = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      s = ~s;
      tick();
      if (i == 10 || i == 255 || i == 300) begin
        n_cmp++;
        if (sel_cnt !== ((i > 255) ? 8'd255 : 8'(i))) begin
          n_bad++; $display("FAIL sel_cnt[%0d]: got %0d want %0d", i, sel_cnt,
                            ((i > 255) ? 255 : i));
        end
        $display("sel_cnt after %0d toggles: %0d", i, sel_cnt);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (sel_cnt !== 8'd0) begin
      n_bad++; $display("FAIL sel_cnt_clear: got %0d want 0", sel_cnt);
    end
    $display("sel_cnt after reset: %0d", sel_cnt);
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; d0 = '0; d1 = '0; s = 1'b0;
    test_reset();
    test_sweep();
    test_toggle();
    test_full_width();
    test_equal_inputs();
    test_mid_reset();
`ifdef TASK2_12_MUX2_SEL_CNT_EN
    test_sel_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_task2_12_mux2
